countdown_timer: RTL

Parametrised successor to the lab countdown timer. Loads a seconds count on `start_timer`, counts down once per internal prescaler tick, and emits a one-cycle `expired` pulse at zero. Adds:
- configurable count width and tick divisor;
- one-shot or periodic (auto-reload) mode;
- pause;
- visible remaining count and busy flag.

It sits beside the alarm/traffic FSMs, which drive `start_timer`/`value` and consume `expired`.

---
 rtl/countdown_timer_if.sv | 30 +++
 rtl/countdown_timer.sv | 107 ++++++++++
 2 files changed

// File: rtl/countdown_timer_if.sv
// Control/status bundle between a sequencing FSM (master) and the countdown timer (slave).
// The master drives the load strobe, the load value and pause. The slave reports expiry, the remaining count and busy status.
interface countdown_timer_if #(
    parameter int VALUE_W = 4
);
    logic               start_timer;
    logic [VALUE_W-1:0] value;
    logic               pause;
    logic               expired;
    logic [VALUE_W-1:0] remaining;
    logic               running;

    modport master (
        output start_timer,
        output value,
        output pause,
        input  expired,
        input  remaining,
        input  running
    );

    modport slave (
        input  start_timer,
        input  value,
        input  pause,
        output expired,
        output remaining,
        output running
    );
endinterface

// File: rtl/countdown_timer.sv
// Prescaled countdown timer with one-shot or auto-reload operation and a pause input.
// It produces a registered one-cycle expired pulse when the count reaches its terminal value.
module countdown_timer #(
    parameter int VALUE_W  = 4,
    parameter int TICK_DIV = 27000000,
    parameter bit PERIODIC = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    countdown_timer_if.slave bus
);
    localparam int                PRESC_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [VALUE_W-1:0] ONE        = VALUE_W'(1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             r_state;
    logic [PRESC_W-1:0] r_presc;
    logic [VALUE_W-1:0] r_remaining;
    logic [VALUE_W-1:0] r_load_val;
    logic               r_expired;
    logic               r_running;

    state_t             w_state_next;
    logic [PRESC_W-1:0] w_presc_next;
    logic [VALUE_W-1:0] w_remaining_next;
    logic [VALUE_W-1:0] w_load_val_next;
    logic               w_expired_next;
    logic               w_tick;

    // When TICK_DIV is 1, PRESC_LAST is 0. The prescaler then never leaves 0, so every unpaused RUN cycle is a tick.
    assign w_tick = (r_state == RUN) && !bus.pause && (r_presc == PRESC_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_presc     <= '0;
            r_remaining <= '0;
            r_load_val  <= '0;
            r_expired   <= 1'b0;
            r_running   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_presc     <= w_presc_next;
            r_remaining <= w_remaining_next;
            r_load_val  <= w_load_val_next;
            r_expired   <= w_expired_next;
            r_running   <= (w_state_next == RUN);
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_presc_next     = r_presc;
        w_remaining_next = r_remaining;
        w_load_val_next  = r_load_val;
        w_expired_next   = 1'b0;

        if (bus.start_timer) begin
            // A restart aborts any run in progress, so the aborted run never raises expired.
            w_load_val_next  = bus.value;
            w_remaining_next = bus.value;
            w_presc_next     = '0;
            if (bus.value != '0) begin
                w_state_next = RUN;
            end else begin
                w_state_next   = IDLE;
                w_expired_next = 1'b1;
            end
        end else begin
            case (r_state)
                RUN: begin
                    if (bus.pause) begin
                        w_presc_next = r_presc;
                    end else if (!w_tick) begin
                        w_presc_next = r_presc + 1'b1;
                    end else begin
                        w_presc_next = '0;
                        if (r_remaining > ONE) begin
                            w_remaining_next = r_remaining - ONE;
                        end else begin
                            // Terminal count. The periodic mode reloads the captured value, never the live input.
                            w_expired_next = 1'b1;
                            if (PERIODIC) begin
                                w_remaining_next = r_load_val;
                            end else begin
                                w_remaining_next = '0;
                                w_state_next     = IDLE;
                            end
                        end
                    end
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    assign bus.expired   = r_expired;
    assign bus.remaining = r_remaining;
    assign bus.running   = r_running;
endmodule
